reflet_boot_ctrl: RTL and testbench
===================================

Name: reflet_boot_ctrl

Overview:
Boot and run sequencer for the Reflet CPU.
- Holds the CPU in reset while it copies a program image from a synchronous boot ROM into system RAM.
- Releases the CPU and passes its system bus through to RAM.
- Detects the quit instruction and either parks or reloads/restarts the CPU.
- Sits between the CPU bus port and the RAM; it is the only master of the CPU reset line.

Parameters:
wordsize, 16, data/address width, identical to the CPU.
rom_words, 256, number of words copied per load; must be >= 1.
load_base, 0, RAM byte address of the first loaded word.
restart_on_quit, 0, 1 = automatically reload and restart after quit; 0 = park until restart.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous active-low reset.
rom_addr  out  clog2(rom_words) (min 1)  boot ROM word index.
rom_data  in  wordsize  ROM read data, valid one cycle after rom_addr.
cpu_addr  in  wordsize  CPU bus address.
cpu_data_out  in  wordsize  CPU write data.
cpu_write_en  in  1  CPU write strobe.
cpu_quit  in  1  CPU quit flag.
cpu_data_in  out  wordsize  read data to CPU.
cpu_reset  out  1  active-low reset to CPU; CPU samples it synchronously.
ram_addr  out  wordsize  RAM address.
ram_data_out  out  wordsize  RAM write data.
ram_write_en  out  1  RAM write strobe.
ram_data_in  in  wordsize  RAM read data.
restart  in  1  single-cycle request to reload and restart.
running  out  1  high while state is RUN.
load_busy  out  1  high while state is LOAD.

Behaviour:
- States: IDLE, LOAD, RUN, HALT. Registered state and counter; bus muxing is combinational from state.
- While reset is low (asynchronous): state=IDLE, counter k=0, cpu_reset=0, running=0, load_busy=0, ram_write_en=0, rom_addr=0.
- IDLE: cpu_reset=0. Transitions to LOAD on the first clk edge after reset deasserts.
- LOAD:
  - cpu_reset=0; the CPU bus is ignored; load_busy=1.
  - Cycle j (j=0..rom_words) drives rom_addr=j for j<rom_words.
  - For j>=1: ram_write_en=1, ram_addr=load_base + (j-1)*(wordsize/8) modulo 2^wordsize, ram_data_out=rom_data.
  - LOAD lasts exactly rom_words+1 cycles, then goes to RUN.
  - rom_addr holds rom_words-1 on the final cycle.
- RUN:
  - cpu_reset=1 and running=1.
  - Pass-through: ram_addr=cpu_addr, ram_data_out=cpu_data_out, ram_write_en=cpu_write_en.
  - The CPU executes its first instruction one cycle after cpu_reset rises.
- cpu_data_in=ram_data_in in all states; it is meaningless outside RUN/HALT.
- RUN with cpu_quit=1 -> HALT on the next edge.
- HALT:
  - cpu_reset=1 (the CPU stays frozen by its quit flag); pass-through remains, but ram_write_en is forced to 0.
  - If restart_on_quit=1: go to LOAD on the next edge.
  - Otherwise stay in HALT until restart=1, then go to LOAD.
- restart in RUN: go to LOAD on the next edge, with cpu_reset=0 from that cycle. This is a forced reload.
- restart in IDLE or LOAD: ignored. A load in progress is never restarted or truncated.
- restart and cpu_quit both high in RUN: restart wins; go directly to LOAD.
- Entering LOAD always clears k to 0, so every load rewrites the full image.
- Reset asserted mid-LOAD or mid-RUN: immediate return to IDLE with all outputs at reset values; ram_write_en drops asynchronously. A partial RAM image is acceptable because a full reload follows.
- No bus cycle is ever issued with both CPU and loader as source. Writes to RAM while cpu_reset=0 come only from the loader.

Test Plan:
- Deassert reset with rom_words=4, ROM={A1,B2,C3,D4}, load_base=0x10 -> writes (0x10,A1),(0x12,B2),(0x14,C3),(0x16,D4) on cycles 2..5 after IDLE; cpu_reset rises on cycle 6; load_busy high exactly 5 cycles.
- In RUN, CPU writes 0x1234 to 0x0040, then reads 0x0040 -> ram_write_en/addr/data mirror the CPU exactly; cpu_data_in=0x1234.
- cpu_quit pulse in RUN with restart_on_quit=0 -> HALT; a CPU write attempt produces no RAM write; restart pulse -> full 5-cycle reload, then RUN with cpu_reset low throughout the reload.
- restart_on_quit=1 and cpu_quit -> HALT for one cycle, then LOAD automatically, then RUN; repeat 3 times with no lost or duplicated ROM words.
- restart and cpu_quit both asserted in the same RUN cycle -> next state is LOAD, not HALT; restart pulsed during LOAD at j=2 -> load completes normally in rom_words+1 cycles.
- Assert reset at LOAD j=2 -> ram_write_en=0 and cpu_reset=0 immediately; after release, the load restarts from k=0; load_base=0xFFFE with rom_words=2 wraps the second address to 0x0000.

Source files
------------

// File: rtl/reflet_boot_ctrl.sv
// Boot and run sequencer for the Reflet CPU: copies the boot ROM image into RAM
// with the CPU held in reset, then passes the CPU bus through until quit/restart.
module reflet_boot_ctrl #(
  parameter int unsigned wordsize        = 16,
  parameter int unsigned rom_words       = 256,
  parameter int unsigned load_base       = 0,
  parameter int unsigned restart_on_quit = 0,
  localparam int unsigned ROM_AW = (rom_words > 1) ? $clog2(rom_words) : 1
) (
  input  logic                clk,
  input  logic                reset,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [wordsize-1:0] rom_data,
  input  logic [wordsize-1:0] cpu_addr,
  input  logic [wordsize-1:0] cpu_data_out,
  input  logic                cpu_write_en,
  input  logic                cpu_quit,
  output logic [wordsize-1:0] cpu_data_in,
  output logic                cpu_reset,
  output logic [wordsize-1:0] ram_addr,
  output logic [wordsize-1:0] ram_data_out,
  output logic                ram_write_en,
  input  logic [wordsize-1:0] ram_data_in,
  input  logic                restart,
  output logic                running,
  output logic                load_busy
);

  localparam int unsigned KW    = $clog2(rom_words + 1);
  localparam int unsigned BYTES = wordsize / 8;

  localparam logic [KW-1:0]       K_LAST   = KW'(rom_words);
  localparam logic [ROM_AW-1:0]   ROM_LAST = ROM_AW'(rom_words - 1);
  localparam logic [wordsize-1:0] BASE     = wordsize'(load_base);
  localparam logic [wordsize-1:0] STRIDE   = wordsize'(BYTES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] HALT = 2'd3;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [KW-1:0]       k;
  logic [KW-1:0]       k_nxt;
  logic [wordsize-1:0] load_offset;

  // State and load counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end
  end

  // Next state; every entry into LOAD restarts the copy from word 0
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    case (state)
      IDLE: begin
        state_nxt = LOAD;
        k_nxt     = '0;
      end
      LOAD: begin
        if (k == K_LAST) begin
          state_nxt = RUN;
          k_nxt     = '0;
        end else begin
          k_nxt = k + KW'(1);
        end
      end
      RUN: begin
        if (restart) begin
          state_nxt = LOAD;
          k_nxt     = '0;
        end else if (cpu_quit) begin
          state_nxt = HALT;
        end
      end
      HALT: begin
        if ((restart_on_quit != 0) || restart) begin
          state_nxt = LOAD;
          k_nxt     = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        k_nxt     = '0;
      end
    endcase
  end

  // Word k-1 lands in RAM on cycle k, since ROM data trails its address by one cycle
  assign load_offset = wordsize'(k - KW'(1)) * STRIDE;
  assign cpu_data_in = ram_data_in;

  // Bus steering: loader owns RAM in IDLE/LOAD, CPU in RUN/HALT
  always_comb begin
    rom_addr     = '0;
    cpu_reset    = 1'b0;
    running      = 1'b0;
    load_busy    = 1'b0;
    ram_addr     = BASE + load_offset;
    ram_data_out = rom_data;
    ram_write_en = 1'b0;
    case (state)
      LOAD: begin
        load_busy    = 1'b1;
        rom_addr     = (k == K_LAST) ? ROM_LAST : ROM_AW'(k);
        ram_write_en = (k != '0);
      end
      RUN: begin
        cpu_reset    = 1'b1;
        running      = 1'b1;
        ram_addr     = cpu_addr;
        ram_data_out = cpu_data_out;
        ram_write_en = cpu_write_en;
      end
      HALT: begin
        cpu_reset    = 1'b1;
        ram_addr     = cpu_addr;
        ram_data_out = cpu_data_out;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_reflet_boot_ctrl.sv
// Scoreboard bench for reflet_boot_ctrl: instance A (4 words, base 0x10, park on quit)
// and instance B (2 words, base 0xFFFE, auto restart on quit).
module tb_reflet_boot_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [1:0]  rom_addr_a;
  logic [15:0] rom_data_a, cpu_addr_a, cpu_data_out_a, cpu_data_in_a;
  logic [15:0] ram_addr_a, ram_data_out_a, ram_data_in_a;
  logic        cpu_write_en_a, cpu_quit_a, cpu_reset_a, ram_write_en_a;
  logic        restart_a, running_a, load_busy_a;

  logic [0:0]  rom_addr_b;
  logic [15:0] rom_data_b, cpu_addr_b, cpu_data_out_b, cpu_data_in_b;
  logic [15:0] ram_addr_b, ram_data_out_b, ram_data_in_b;
  logic        cpu_write_en_b, cpu_quit_b, cpu_reset_b, ram_write_en_b;
  logic        restart_b, running_b, load_busy_b;

  reflet_boot_ctrl #(.wordsize(16), .rom_words(4), .load_base(32'h0010), .restart_on_quit(0)) dut_a (
    .clk(clk), .reset(reset), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .cpu_addr(cpu_addr_a), .cpu_data_out(cpu_data_out_a), .cpu_write_en(cpu_write_en_a),
    .cpu_quit(cpu_quit_a), .cpu_data_in(cpu_data_in_a), .cpu_reset(cpu_reset_a),
    .ram_addr(ram_addr_a), .ram_data_out(ram_data_out_a), .ram_write_en(ram_write_en_a),
    .ram_data_in(ram_data_in_a), .restart(restart_a), .running(running_a), .load_busy(load_busy_a)
  );

  reflet_boot_ctrl #(.wordsize(16), .rom_words(2), .load_base(32'hFFFE), .restart_on_quit(1)) dut_b (
    .clk(clk), .reset(reset), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .cpu_addr(cpu_addr_b), .cpu_data_out(cpu_data_out_b), .cpu_write_en(cpu_write_en_b),
    .cpu_quit(cpu_quit_b), .cpu_data_in(cpu_data_in_b), .cpu_reset(cpu_reset_b),
    .ram_addr(ram_addr_b), .ram_data_out(ram_data_out_b), .ram_write_en(ram_write_en_b),
    .ram_data_in(ram_data_in_b), .restart(restart_b), .running(running_b), .load_busy(load_busy_b)
  );

  // Synchronous boot ROMs and simple RAMs with combinational read
  logic [15:0] rom_a [4];
  logic [15:0] rom_b [2];
  logic [15:0] mem_a [65536];
  logic [15:0] mem_b [65536];

  always @(posedge clk) begin
    rom_data_a <= rom_a[rom_addr_a];
    rom_data_b <= rom_b[rom_addr_b];
    if (ram_write_en_a) mem_a[ram_addr_a] <= ram_data_out_a;
    if (ram_write_en_b) mem_b[ram_addr_b] <= ram_data_out_b;
  end
  assign ram_data_in_a = mem_a[ram_addr_a];
  assign ram_data_in_b = mem_b[ram_addr_b];

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic        loader;
  } wr_t;

  typedef struct packed {
    logic       lb;
    logic       cr;
    logic       we;
    logic       run;
    logic [1:0] ra;
  } obs_t;

  wr_t         exp_a[$];
  wr_t         exp_b[$];
  logic [15:0] model_a [logic [15:0]];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference image: word i goes to base + 2*i modulo 2^16
  task automatic push_load(input int w);
    logic [15:0] a;
    if (w == 0) begin
      for (int i = 0; i < 4; i++) begin
        a = 16'((32'h0010 + 2 * i) % 65536);
        exp_a.push_back(wr_t'{a, rom_a[i], 1'b1});
        model_a[a] = rom_a[i];
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        a = 16'((32'hFFFE + 2 * i) % 65536);
        exp_b.push_back(wr_t'{a, rom_b[i], 1'b1});
      end
    end
  endtask

  task automatic sb_pop(input int w, input logic [15:0] addr, input logic [15:0] data, input logic crst);
    wr_t   e;
    string t;
    t = (w == 0) ? "A" : "B";
    if ((w == 0 && exp_a.size() == 0) || (w == 1 && exp_b.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s unexpected_write: got write addr %h data %h, required no write at %0t", t, addr, data, $time);
    end else begin
      if (w == 0) e = exp_a.pop_front();
      else        e = exp_b.pop_front();
      chk({t, " write_addr"}, 32'(addr), 32'(e.addr));
      chk({t, " write_data"}, 32'(data), 32'(e.data));
      chk({t, " write_cpu_reset"}, 32'(crst), 32'(!e.loader));
    end
  endtask

  // Monitor: every RAM write strobe must match the next expected write
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (ram_write_en_a) sb_pop(0, ram_addr_a, ram_data_out_a, cpu_reset_a);
      if (ram_write_en_b) sb_pop(1, ram_addr_b, ram_data_out_b, cpu_reset_b);
    end
  end

  function automatic obs_t get_obs(input int w);
    if (w == 0) return obs_t'{load_busy_a, cpu_reset_a, ram_write_en_a, running_a, rom_addr_a};
    else        return obs_t'{load_busy_b, cpu_reset_b, ram_write_en_b, running_b, {1'b0, rom_addr_b}};
  endfunction

  // Expects the next negedge to be load cycle j=0; ends on the first RUN negedge
  task automatic do_load(input int w, input int n);
    obs_t  o;
    string t;
    t = (w == 0) ? "A" : "B";
    for (int j = 0; j <= n; j++) begin
      @(negedge clk);
      o = get_obs(w);
      chk({t, " load_busy"}, 32'(o.lb), 32'd1);
      chk({t, " load_cpu_reset"}, 32'(o.cr), 32'd0);
      chk({t, " load_running"}, 32'(o.run), 32'd0);
      chk({t, " load_write_en"}, 32'(o.we), 32'(j >= 1));
      chk({t, " rom_addr"}, 32'(o.ra), 32'((j < n) ? j : n - 1));
    end
    @(negedge clk);
    o = get_obs(w);
    chk({t, " run_load_busy"}, 32'(o.lb), 32'd0);
    chk({t, " run_running"}, 32'(o.run), 32'd1);
    chk({t, " run_cpu_reset"}, 32'(o.cr), 32'd1);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] wa [6];
  logic [15:0] a16;
  logic [15:0] d16;

  initial begin
    reset = 1'b0;
    cpu_addr_a = '0; cpu_data_out_a = '0; cpu_write_en_a = 1'b0; cpu_quit_a = 1'b0; restart_a = 1'b0;
    cpu_addr_b = '0; cpu_data_out_b = '0; cpu_write_en_b = 1'b0; cpu_quit_b = 1'b0; restart_b = 1'b0;
    for (int i = 0; i < 4; i++) rom_a[i] = 16'($urandom);
    for (int i = 0; i < 2; i++) rom_b[i] = 16'($urandom);
    repeat (3) cyc();

    @(negedge clk);
    chk("A reset_cpu_reset", 32'(cpu_reset_a), 32'd0);
    chk("A reset_running", 32'(running_a), 32'd0);
    chk("A reset_load_busy", 32'(load_busy_a), 32'd0);
    chk("A reset_write_en", 32'(ram_write_en_a), 32'd0);
    chk("A reset_rom_addr", 32'(rom_addr_a), 32'd0);
    chk("B reset_cpu_reset", 32'(cpu_reset_b), 32'd0);
    chk("B reset_write_en", 32'(ram_write_en_b), 32'd0);

    push_load(0);
    push_load(1);
    cyc();
    reset = 1'b1;
    @(negedge clk);
    chk("A idle_load_busy", 32'(load_busy_a), 32'd0);
    chk("A idle_cpu_reset", 32'(cpu_reset_a), 32'd0);
    fork
      do_load(0, 4);
      do_load(1, 2);
    join

    // CPU traffic through A in RUN
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i == 0) begin
        a16 = 16'h0040;
        d16 = 16'h1234;
      end else begin
        a16 = 16'($urandom_range(32'h0100, 32'hFFF0));
        a16[0] = 1'b0;
        d16 = 16'($urandom);
      end
      cpu_addr_a = a16; cpu_data_out_a = d16; cpu_write_en_a = 1'b1;
      exp_a.push_back(wr_t'{a16, d16, 1'b0});
      model_a[a16] = d16;
      wa[i] = a16;
    end
    cyc();
    cpu_write_en_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cpu_addr_a = wa[i];
      @(negedge clk);
      chk("A read_data", 32'(cpu_data_in_a), 32'(model_a[wa[i]]));
      chk("A read_ram_addr", 32'(ram_addr_a), 32'(wa[i]));
      chk("A read_write_en", 32'(ram_write_en_a), 32'd0);
      cyc();
    end

    // Quit parks A in HALT; CPU write attempts must not reach RAM
    cpu_quit_a = 1'b1;
    cyc();
    cpu_quit_a = 1'b0; cpu_addr_a = 16'h0050; cpu_data_out_a = 16'hDEAD; cpu_write_en_a = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("A halt_running", 32'(running_a), 32'd0);
      chk("A halt_cpu_reset", 32'(cpu_reset_a), 32'd1);
      chk("A halt_write_en", 32'(ram_write_en_a), 32'd0);
      chk("A halt_load_busy", 32'(load_busy_a), 32'd0);
      chk("A halt_ram_addr", 32'(ram_addr_a), 32'h0050);
      cyc();
    end
    cpu_write_en_a = 1'b0;
    restart_a = 1'b1;
    push_load(0);
    cyc();
    restart_a = 1'b0;
    do_load(0, 4);

    // restart and quit together: restart wins
    cyc();
    cpu_quit_a = 1'b1; restart_a = 1'b1;
    push_load(0);
    cyc();
    cpu_quit_a = 1'b0; restart_a = 1'b0;
    do_load(0, 4);

    // restart during LOAD j=2 is ignored
    cyc();
    restart_a = 1'b1;
    push_load(0);
    cyc();
    restart_a = 1'b0;
    fork
      do_load(0, 4);
      begin
        cyc();
        cyc();
        restart_a = 1'b1;
        cyc();
        restart_a = 1'b0;
      end
    join

    // B reloads automatically after each quit
    for (int r = 0; r < 3; r++) begin
      cyc();
      push_load(1);
      cpu_quit_b = 1'b1;
      cyc();
      cpu_quit_b = 1'b0;
      @(negedge clk);
      chk("B halt_running", 32'(running_b), 32'd0);
      chk("B halt_cpu_reset", 32'(cpu_reset_b), 32'd1);
      chk("B halt_load_busy", 32'(load_busy_b), 32'd0);
      cyc();
      do_load(1, 2);
    end

    // Reset at A load cycle j=2, then a full reload from word 0
    cyc();
    restart_a = 1'b1;
    push_load(0);
    cyc();
    restart_a = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("A midload_reset_write_en", 32'(ram_write_en_a), 32'd0);
    chk("A midload_reset_cpu_reset", 32'(cpu_reset_a), 32'd0);
    chk("A midload_reset_load_busy", 32'(load_busy_a), 32'd0);
    chk("A midload_reset_rom_addr", 32'(rom_addr_a), 32'd0);
    chk("B midload_reset_cpu_reset", 32'(cpu_reset_b), 32'd0);
    chk("A partial_image_written", 32'(exp_a.size()), 32'd3);
    exp_a.delete();
    exp_b.delete();
    cyc();
    cyc();
    push_load(0);
    push_load(1);
    reset = 1'b1;
    @(negedge clk);
    chk("A idle2_load_busy", 32'(load_busy_a), 32'd0);
    fork
      do_load(0, 4);
      do_load(1, 2);
    join

    repeat (3) cyc();
    @(negedge clk);
    chk("A queue_empty", 32'(exp_a.size()), 32'd0);
    chk("B queue_empty", 32'(exp_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required the sequence to complete");
    $fatal(1, "watchdog expired");
  end

endmodule
